// File: rtl/rst_seq.sv
// Reset release sequencer: holds every stage in reset, then releases stage 0..N-1 in order,
// gated by each stage's synchronized ready ack plus a fixed gap, with an ack timeout trap.
module rst_seq #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYC    = 8,
  parameter int STAGE_GAP   = 4,
  parameter int ACK_TIMEOUT = 32,
  parameter int CNT_W       = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Sw_rst_req,
  input  logic [NUM_STAGES-1:0] Stage_ack,
  output logic [NUM_STAGES-1:0] Rst_out,
  output logic [2:0]            Cur_stage,
  output logic                  Seq_done,
  output logic                  Seq_err
);

  typedef enum logic [2:0] {HOLD, WAIT_ACK, GAP, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [2:0]       LAST_STG  = 3'(NUM_STAGES - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_STAGES-1:0]   ack_meta;
  logic [NUM_STAGES-1:0]   sack;
  logic [7:0]              sack_ext;
  logic                    timeout;

  // Two-flop synchronizer per ack bit; the FSM only ever looks at sack.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ack_meta <= '0;
      sack     <= '0;
    end else begin
      ack_meta <= Stage_ack;
      sack     <= ack_meta;
    end
  end

  // Zero-padded copy so a 3-bit stage index never selects out of range.
  always_comb begin
    sack_ext = '0;
    sack_ext[NUM_STAGES-1:0] = sack;
  end

  assign timeout = (ACK_TIMEOUT != 0) && (cnt == TO_LAST);

  // Releases are a left shift of Rst_out, which keeps released stages a contiguous low run.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= HOLD;
      cnt       <= '0;
      Rst_out   <= '1;
      Cur_stage <= '0;
      Seq_done  <= 1'b0;
      Seq_err   <= 1'b0;
    end else if (Sw_rst_req) begin
      state     <= HOLD;
      cnt       <= '0;
      Rst_out   <= '1;
      Cur_stage <= '0;
      Seq_done  <= 1'b0;
      Seq_err   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state   <= WAIT_ACK;
            cnt     <= '0;
            Rst_out <= Rst_out << 1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (sack_ext[Cur_stage]) begin
            state <= GAP;
            cnt   <= '0;
          end else if (timeout) begin
            state   <= ERR;
            Rst_out <= '1;
            Seq_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            if (Cur_stage == LAST_STG) begin
              state    <= DONE;
              Seq_done <= 1'b1;
            end else begin
              state     <= WAIT_ACK;
              cnt       <= '0;
              Cur_stage <= Cur_stage + 3'd1;
              Rst_out   <= Rst_out << 1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= DONE;
        ERR:     state <= ERR;
        default: state <= HOLD;
      endcase
    end
  end

endmodule
